// File: rtl/uart_tx_scheduler_if.sv
// Byte-producer / UART-tx handshake bundle for uart_tx_scheduler.
// master = producers plus UART model side, slave = the scheduler itself.
interface uart_tx_scheduler_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_full;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_full;
  logic [1:0] drop;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] grant;

  modport master (
    output a_valid, a_data, b_valid, b_data, tx_busy,
    input  a_full, b_full, drop, tx_data, tx_start, grant
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, tx_busy,
    output a_full, b_full, drop, tx_data, tx_start, grant
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between two byte FIFOs (A, B).
// Optional UART_TX_SCHED_STATS_EN adds saturating sent_a/sent_b/lost counters.
module uart_tx_scheduler #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_scheduler_if.slave bus
`ifdef UART_TX_SCHED_STATS_EN
  ,
  output logic [15:0]        sent_a,
  output logic [15:0]        sent_b,
  output logic [7:0]         lost
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [7:0]      timer;
  logic            rr_b;       // source favoured on contention: 0 = A, 1 = B
  logic [1:0]      push_req;
  logic [1:0]      push_ok;
  logic [1:0]      pop;
  logic [1:0]      full;
  logic [1:0]      nonempty;
  logic [1:0][7:0] push_data;
  logic [1:0][7:0] head;
  logic            pick_any;
  logic            pick_b;

  assign push_req  = {bus.b_valid, bus.a_valid};
  assign push_data = {bus.b_data, bus.a_data};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pick_b = 1'b0;
    case (nonempty)
      2'b10:   pick_b = 1'b1;
      2'b11:   pick_b = rr_b;
      default: pick_b = 1'b0;
    endcase
  end

  assign pick_any = |nonempty;
  assign pop      = (state == IDLE && pick_any) ? (pick_b ? 2'b10 : 2'b01) : 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full[i]     = (count == CW'(DEPTH));
    assign nonempty[i] = (count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok[i]  = push_req[i] && (!full[i] || pop[i]);
    assign head[i]     = mem[rd_ptr];

    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
      if (push_ok[i]) mem[wr_ptr] <= push_data[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])     rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_ok[i]) - CW'(pop[i]);
      end
    end
  end

  assign bus.a_full = full[0];
  assign bus.b_full = full[1];
  assign bus.drop   = push_req & full & ~pop;

  // NOTE: state and registered outputs use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      rr_b         <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.grant    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.tx_data  <= head[pick_b];
            bus.grant    <= pick_b ? 2'b10 : 2'b01;
            bus.tx_start <= 1'b1;
            rr_b         <= ~pick_b;
            state        <= START;
          end
        end
        START: begin
          // tx_busy is deliberately not looked at here.
          bus.tx_start <= 1'b0;
          timer        <= '0;
          state        <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMEOUT_LAST) begin
            bus.grant <= 2'b00;
            state     <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            bus.grant <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_SCHED_STATS_EN
  logic tx_done;
  logic tx_lost;

  assign tx_done = (state == WAIT_DONE) && !bus.tx_busy;
  assign tx_lost = (state == WAIT_BUSY) && !bus.tx_busy && (timer == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_a <= '0;
      sent_b <= '0;
      lost   <= '0;
    end else begin
      if (tx_done && bus.grant[0] && sent_a != 16'hffff) sent_a <= sent_a + 16'd1;
      if (tx_done && bus.grant[1] && sent_b != 16'hffff) sent_b <= sent_b + 16'd1;
      if (tx_lost && lost != 8'hff)                      lost   <= lost + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed + randomized bench for uart_tx_scheduler: queue-based model of the
// two FIFOs and round-robin choice, plus a simple UART busy responder.
module tb_uart_tx_scheduler;
  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] sent_a;
  logic [15:0] sent_b;
  logic [7:0]  lost;
`endif

  uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UART_TX_SCHED_STATS_EN
    ,
    .sent_a(sent_a),
    .sent_b(sent_b),
    .lost  (lost)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] grant;
    int         cyc;
  } tx_ev_t;

  tx_ev_t     tx_log[$];
  int         cyc          = 0;
  int         busy_cnt     = 0;
  int         busy_len     = 10;
  bit         uart_respond = 1'b1;
  int         n_checks     = 0;
  int         n_fail       = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         rr_b         = 1'b0;

  // UART model: records each tx_start cycle, then holds tx_busy for busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (bus.tx_start) begin
        tx_log.push_back('{bus.tx_data, bus.grant, cyc});
        if (uart_respond) busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.tx_busy = (busy_cnt > 0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input bit a_en, input logic [7:0] a_d, input bit b_en,
                       input logic [7:0] b_d, output logic [1:0] drop_seen,
                       output logic [1:0] full_seen);
    bus.a_valid = a_en;
    bus.a_data  = a_d;
    bus.b_valid = b_en;
    bus.b_data  = b_d;
    @(negedge clk);
    drop_seen = bus.drop;
    full_seen = {bus.b_full, bus.a_full};
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic model_push(input bit to_b, input logic [7:0] d);
    if (to_b) qb.push_back(d);
    else      qa.push_back(d);
  endtask

  // Next byte on the line: the only pending source, else the round-robin favourite.
  task automatic model_pick(output logic [7:0] d, output logic [1:0] g);
    bit use_b;
    d = 8'h00;
    g = 2'b00;
    if (qa.size() != 0 || qb.size() != 0) begin
      use_b = (qa.size() == 0) ? 1'b1 : (qb.size() == 0) ? 1'b0 : rr_b;
      if (use_b) begin
        d = qb.pop_front();
        g = 2'b10;
      end else begin
        d = qa.pop_front();
        g = 2'b01;
      end
      rr_b = !use_b;
    end
  endtask

  task automatic expect_tx(input string tag, output int start_cyc);
    int         waited = 0;
    tx_ev_t     ev;
    logic [7:0] d;
    logic [1:0] g;
    start_cyc = -1;
    while (tx_log.size() == 0 && waited < 200) begin
      tick();
      waited++;
    end
    check({tag, "_started"}, 32'(tx_log.size() != 0), 32'd1);
    if (tx_log.size() != 0) begin
      ev = tx_log.pop_front();
      model_pick(d, g);
      check({tag, "_data"}, 32'(ev.data), 32'(d));
      check({tag, "_grant"}, 32'(ev.grant), 32'(g));
      start_cyc = ev.cyc;
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    while (bus.grant !== 2'b00 && waited < 200) begin
      tick();
      waited++;
    end
    check(tag, 32'(bus.grant), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    tick(n);
    check(tag, 32'(tx_log.size()), 32'd0);
  endtask

  initial begin
    logic [1:0] dr;
    logic [1:0] fl;
    logic [7:0] d;
    logic [7:0] da;
    logic [7:0] db;
    int         s1;
    int         s2;
    int         na;
    int         nb;
    int         nmax;
    bit         side;

    bus.a_valid = 1'b0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_data  = 8'h00;

    // Reset state
    tick(3);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_grant",    32'(bus.grant),    32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'd0);
    check("rst_drop",     32'(bus.drop),     32'd0);
    check("rst_full",     32'({bus.b_full, bus.a_full}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Single byte, UART busy for 10 cycles
    busy_len = 10;
    drive(1'b1, 8'h41, 1'b0, 8'h00, dr, fl);
    model_push(1'b0, 8'h41);
    check("single_drop", 32'(dr), 32'd0);
    expect_tx("single", s1);
    wait_idle("single_idle");
    expect_quiet("single_quiet", 5);

    // Reset in the middle of WAIT_DONE discards in-flight and queued bytes
    busy_len = 10;
    d = 8'($urandom_range(1, 255));
    drive(1'b1, d, 1'b0, 8'h00, dr, fl);
    model_push(1'b0, d);
    expect_tx("rstmid_first", s1);
    drive(1'b1, 8'($urandom), 1'b0, 8'h00, dr, fl);
    drive(1'b1, 8'($urandom), 1'b0, 8'h00, dr, fl);
    check("rstmid_pre_grant", 32'(bus.grant), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_start", 32'(bus.tx_start), 32'd0);
    check("rstmid_grant",    32'(bus.grant),    32'd0);
    check("rstmid_tx_data",  32'(bus.tx_data),  32'd0);
    check("rstmid_drop",     32'(bus.drop),     32'd0);
    qa.delete();
    qb.delete();
    rr_b = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstmid_a_full", 32'(bus.a_full), 32'd0);
    expect_quiet("rstmid_fifo_empty", 20);

    // Fairness from rr = A: A={11,12}, B={21,22} go out 11,21,12,22
    busy_len = $urandom_range(3, 8);
    drive(1'b1, 8'h11, 1'b1, 8'h21, dr, fl);
    model_push(1'b0, 8'h11);
    model_push(1'b1, 8'h21);
    drive(1'b1, 8'h12, 1'b1, 8'h22, dr, fl);
    model_push(1'b0, 8'h12);
    model_push(1'b1, 8'h22);
    for (int k = 0; k < 4; k++) expect_tx($sformatf("fair%0d", k), s1);
    wait_idle("fair_idle");
    expect_quiet("fair_quiet", 5);

    // Overflow: five pushes to A while the UART is busy with a B byte
    busy_len = 30;
    d = 8'($urandom);
    drive(1'b0, 8'h00, 1'b1, d, dr, fl);
    model_push(1'b1, d);
    expect_tx("ovf_carrier", s1);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      drive(1'b1, d, 1'b0, 8'h00, dr, fl);
      if (k < 4) begin
        check($sformatf("ovf_drop%0d", k), 32'(dr), 32'd0);
        model_push(1'b0, d);
      end else begin
        check("ovf_drop_5th", 32'(dr), 32'd1);
        check("ovf_full_5th", 32'(fl[0]), 32'd1);
      end
    end
    for (int k = 0; k < 4; k++) expect_tx($sformatf("ovf_tx%0d", k), s1);
    wait_idle("ovf_idle");
    expect_quiet("ovf_quiet", 5);

    // Timeout: no busy response; the next byte starts BUSY_TIMEOUT+2 cycles later
    uart_respond = 1'b0;
    busy_len     = 5;
    d = 8'($urandom);
    drive(1'b1, d, 1'b0, 8'h00, dr, fl);
    model_push(1'b0, d);
    expect_tx("tmo_first", s1);
    uart_respond = 1'b1;
    d = 8'($urandom);
    drive(1'b1, d, 1'b0, 8'h00, dr, fl);
    model_push(1'b0, d);
    expect_tx("tmo_second", s2);
    check("tmo_spacing", 32'(s2 - s1), 32'(BUSY_TIMEOUT + 2));
`ifdef UART_TX_SCHED_STATS_EN
    check("tmo_lost", 32'(lost), 32'd1);
`endif
    wait_idle("tmo_idle");
    expect_quiet("tmo_quiet", 5);

    // Push into full FIFO B in the very cycle it is popped
    busy_len = 20;
    d = 8'($urandom);
    drive(1'b1, d, 1'b0, 8'h00, dr, fl);
    model_push(1'b0, d);
    expect_tx("pp_carrier", s1);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      drive(1'b0, 8'h00, 1'b1, d, dr, fl);
      model_push(1'b1, d);
      check($sformatf("pp_fill_drop%0d", k), 32'(dr), 32'd0);
    end
    check("pp_full_before", 32'(bus.b_full), 32'd1);
    wait_idle("pp_reach_idle");
    d = 8'($urandom);
    drive(1'b0, 8'h00, 1'b1, d, dr, fl);
    model_push(1'b1, d);
    check("pp_drop", 32'(dr), 32'd0);
    check("pp_full_during", 32'(fl[1]), 32'd1);
    check("pp_full_after", 32'(bus.b_full), 32'd1);
    for (int k = 0; k < 5; k++) expect_tx($sformatf("pp_tx%0d", k), s1);
    wait_idle("pp_idle");
    expect_quiet("pp_quiet", 5);

    // Random bursts into both FIFOs while a carrier byte is on the line
    for (int r = 0; r < 4; r++) begin
      busy_len = $urandom_range(8, 16);
      side = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      drive(!side, d, side, d, dr, fl);
      model_push(side, d);
      expect_tx($sformatf("rnd%0d_carrier", r), s1);
      na   = $urandom_range(0, DEPTH);
      nb   = $urandom_range(0, DEPTH);
      nmax = (na > nb) ? na : nb;
      for (int k = 0; k < nmax; k++) begin
        da = 8'($urandom);
        db = 8'($urandom);
        drive(k < na, da, k < nb, db, dr, fl);
        if (k < na) model_push(1'b0, da);
        if (k < nb) model_push(1'b1, db);
        check($sformatf("rnd%0d_drop%0d", r, k), 32'(dr), 32'd0);
      end
      for (int k = 0; k < na + nb; k++) expect_tx($sformatf("rnd%0d_tx%0d", r, k), s1);
      wait_idle($sformatf("rnd%0d_idle", r));
      expect_quiet($sformatf("rnd%0d_quiet", r), 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
